// File: rtl/pflink_crc_framer.sv
// Frame pass-through with a CRC-16 (x^16+x^12+x^5+1) trailer word appended
// after the last payload word of every frame. One output register stage,
// valid/ready on both sides, full throughput inside a frame.
module pflink_crc_framer #(
    parameter logic [15:0] TRAILER_TAG = 16'hCC00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_we,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_we,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] crc_value,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int          DATA_W   = 32;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        TRAILER = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Output register stage
    logic [DATA_W-1:0] data_p0;
    logic [1:0]        we_p0;
    logic              last_p0;
    logic              vld_p0;

    logic              in_acc;
    logic              out_acc;
    logic              trailer_load;
    logic [DATA_W-1:0] crc_in;
    logic [15:0]       crc_seed;

    // MSB-first serial CRC over one 32-bit word, unrolled into one cycle.
    function automatic logic [15:0] crc_step(input logic [15:0] seed,
                                             input logic [DATA_W-1:0] data);
        logic [15:0] c;
        logic        fb;
        c = seed;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    // Upstream may only push while not emitting a trailer and the output slot frees up.
    assign in_ready = !reset && (state != TRAILER) && (!vld_p0 || out_ready);
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = vld_p0 && out_ready;

    // The trailer goes in once the last payload word has left (or the slot is empty).
    assign trailer_load = (state == TRAILER) && (!vld_p0 || (out_ready && !last_p0));

    // Disabled halfwords contribute zeros to the CRC but are forwarded untouched.
    assign crc_in   = {in_we[1] ? in_data[31:16] : 16'h0000,
                       in_we[0] ? in_data[15:0]  : 16'h0000};
    assign crc_seed = (state == IDLE) ? 16'h0000 : crc_value;

    assign out_data  = data_p0;
    assign out_we    = we_p0;
    assign out_last  = last_p0;
    assign out_valid = vld_p0;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: payload phases advance on accepted words, trailer on its handoff.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_acc) begin
                    state_next = in_last ? TRAILER : DATA;
                end
            end
            DATA: begin
                if (in_acc && in_last) begin
                    state_next = TRAILER;
                end
            end
            TRAILER: begin
                if (out_acc && last_p0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Running CRC; restarts from zero on the first word of each frame and holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_value <= 16'h0000;
        end else if (in_acc) begin
            crc_value <= crc_step(crc_seed, crc_in);
        end
    end

    // Output register: payload word, trailer word, or drain; holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_p0 <= '0;
            we_p0   <= 2'b00;
            last_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end else if (in_acc) begin
            data_p0 <= in_data;
            we_p0   <= in_we;
            last_p0 <= 1'b0;
            vld_p0  <= 1'b1;
        end else if (trailer_load) begin
            data_p0 <= {TRAILER_TAG, crc_value};
            we_p0   <= 2'b11;
            last_p0 <= 1'b1;
            vld_p0  <= 1'b1;
        end else if (out_acc) begin
            last_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end
    end

    // Count delivered trailers; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= 16'h0000;
        end else if (out_acc && last_p0) begin
            frame_count <= frame_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_pflink_crc_framer.sv
// Bench for pflink_crc_framer: fixed vector table, randomized frames with
// backpressure against a polynomial-division CRC model, reset and wrap cases.
module tb_pflink_crc_framer;

    localparam logic [15:0] TAG = 16'hCC00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic [1:0]  in_we = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_we;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic [15:0] crc_value;
    logic [15:0] frame_count;
    logic        busy;

    always #5 clk = ~clk;

    pflink_crc_framer #(.TRAILER_TAG(TAG)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_we(in_we), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .out_data(out_data), .out_we(out_we), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready),
        .crc_value(crc_value), .frame_count(frame_count), .busy(busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  we;
        logic        last;
    } word_t;

    typedef struct {
        logic [31:0] w0;
        logic [1:0]  we0;
        logic [31:0] w1;
        logic [1:0]  we1;
        int          n;
        logic [31:0] trailer;
    } vec_t;

    word_t       exp_q[$];
    int          errs = 0;
    int          checks = 0;
    int          bp_mode = 0;
    bit          rand_gap = 0;
    bit          mon_en = 0;
    bit          in_trl = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic [1:0]  prev_we = 2'b00;
    logic        prev_last = 1'b0;
    logic [15:0] fc_exp = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        checks++;
        errs++;
        $display("FAIL %s: bound expired or event not expected", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC: remainder of (message * x^16) divided by the generator.
    function automatic logic [15:0] model_crc(input logic [31:0] msg[$]);
        bit          bits[$];
        logic [16:0] rem;
        foreach (msg[k]) begin
            for (int b = 31; b >= 0; b--) bits.push_back(msg[k][b]);
        end
        for (int z = 0; z < 16; z++) bits.push_back(1'b0);
        rem = '0;
        foreach (bits[k]) begin
            rem = {rem[15:0], bits[k]};
            if (rem[16]) rem = rem ^ 17'h11021;
        end
        return rem[15:0];
    endfunction

    task automatic push_exp(input logic [31:0] d, input logic [1:0] we, input logic last);
        word_t e;
        e.data = d;
        e.we   = we;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [1:0] we, input logic last);
        bit acc;
        int n;
        if (rand_gap) repeat ($urandom_range(0, 2)) step();
        in_data  = d;
        in_we    = we;
        in_last  = last;
        in_valid = 1'b1;
        acc = 0;
        n = 0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) fail_note("send_timeout");
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) fail_note("drain_timeout");
    endtask

    task automatic send_rand_frame();
        int          n;
        logic [31:0] d[$];
        logic [1:0]  w[$];
        logic [31:0] m[$];
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
            d.push_back(($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
            w.push_back(2'($urandom_range(0, 3)));
            m.push_back(d[i] & {{16{w[i][1]}}, {16{w[i][0]}}});
            push_exp(d[i], w[i], 1'b0);
        end
        push_exp({TAG, model_crc(m)}, 2'b11, 1'b1);
        for (int i = 0; i < n; i++) send_word(d[i], w[i], (i == n - 1));
        fc_exp = fc_exp + 16'h0001;
    endtask

    // Downstream ready: always, random, or held low.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 99) < 60);
            default: out_ready = 1'b0;
        endcase
    end

    // Output monitor: in-order scoreboard, stall stability, no intake during trailer.
    always @(negedge clk) begin : monitor
        word_t e;
        if (mon_en) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_we", 32'(out_we), 32'(prev_we));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (in_trl) chk("trailer_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_note("unexpected_word");
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_we", 32'(out_we), 32'(e.we));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
                if (out_last) in_trl = 0;
            end
            if (in_valid && in_ready && in_last) in_trl = 1;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_we    = out_we;
            prev_last  = out_last;
        end else begin
            prev_stall = 0;
            in_trl     = 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[6];

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_crc", 32'(crc_value), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1;
        step();

        // Fixed vectors: {words, enables} -> trailer
        tbl[0] = '{32'h00000001, 2'b11, 32'h0, 2'b00, 1, 32'hCC001021};
        tbl[1] = '{32'h00000001, 2'b11, 32'h00000000, 2'b11, 2, 32'hCC00AA51};
        tbl[2] = '{32'hFFFF0001, 2'b01, 32'h0, 2'b00, 1, 32'hCC001021};
        tbl[3] = '{32'h12345678, 2'b00, 32'h0, 2'b00, 1, 32'hCC000000};
        tbl[4] = '{32'h00000001, 2'b10, 32'h0, 2'b00, 1, 32'hCC000000};
        tbl[5] = '{32'h00010000, 2'b10, 32'h0, 2'b00, 1, 32'hCC003730};
        for (int i = 0; i < 6; i++) begin
            push_exp(tbl[i].w0, tbl[i].we0, 1'b0);
            if (tbl[i].n == 2) push_exp(tbl[i].w1, tbl[i].we1, 1'b0);
            push_exp(tbl[i].trailer, 2'b11, 1'b1);
            send_word(tbl[i].w0, tbl[i].we0, (tbl[i].n == 1));
            if (tbl[i].n == 2) send_word(tbl[i].w1, tbl[i].we1, 1'b1);
            wait_drain();
            fc_exp = fc_exp + 16'h0001;
            chk("vec_frame_count", 32'(frame_count), 32'(fc_exp));
            chk("vec_crc_hold", 32'(crc_value), 32'(tbl[i].trailer[15:0]));
            chk("vec_busy_idle", 32'(busy), 32'd0);
        end

        // Random frames with backpressure and input gaps
        bp_mode  = 1;
        rand_gap = 1;
        for (int f = 0; f < 100; f++) send_rand_frame();
        wait_drain();
        bp_mode  = 0;
        rand_gap = 0;
        step();
        chk("rand_frame_count", 32'(frame_count), 32'(fc_exp));
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame: two of four words sent, then reset with a word offered
        mon_en = 0;
        send_word(32'hDEADBEEF, 2'b11, 1'b0);
        send_word(32'h00000005, 2'b11, 1'b0);
        chk("mid_busy", 32'(busy), 32'd1);
        in_data  = 32'hA5A5A5A5;
        in_we    = 2'b11;
        in_valid = 1'b1;
        reset    = 1'b1;
        step();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_out_we", 32'(out_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_crc", 32'(crc_value), 32'd0);
        chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("mid_post_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        fc_exp = 16'h0000;
        mon_en = 1;
        step();
        push_exp(32'h00000001, 2'b11, 1'b0);
        push_exp(32'hCC001021, 2'b11, 1'b1);
        send_word(32'h00000001, 2'b11, 1'b1);
        wait_drain();
        chk("after_rst_frame_count", 32'(frame_count), 32'd1);

        // frame_count wrap
        force dut.frame_count = 16'hFFFF;
        step();
        release dut.frame_count;
        step();
        chk("wrap_preload", 32'(frame_count), 32'h0000FFFF);
        push_exp(32'h00000001, 2'b11, 1'b0);
        push_exp(32'hCC001021, 2'b11, 1'b1);
        send_word(32'h00000001, 2'b11, 1'b1);
        wait_drain();
        chk("wrap_frame_count", 32'(frame_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
